// File: rtl/alu_pkg.sv
// Shared ALU command encoding and opcode legality check for the pipeline and the issuer.
package alu_pkg;

    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_MUL = 8'h02;
    localparam logic [7:0] ALU_CLR = 8'h03;

    localparam int unsigned INSTR_W = 32;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == ALU_ADD) || (op == ALU_MUL) || (op == ALU_CLR);
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Link between the opcode filter in instr_issue (master) and the instruction FIFO (slave).
interface instr_issue_if
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic               push;
    logic               pop;
    logic               flush;
    logic [INSTR_W-1:0] wdata;
    logic [INSTR_W-1:0] rdata;
    logic [LW-1:0]      level;

    modport master (output push, pop, flush, wdata, input  rdata, level);
    modport slave  (input  push, pop, flush, wdata, output rdata, level);

endinterface

// File: rtl/issue_fifo.sv
// Circular instruction buffer; pointers wrap modulo DEPTH and level tells full from empty.
module issue_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    instr_issue_if.slave fifo
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (fifo.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (fifo.push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (fifo.pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({fifo.push, fifo.pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left out of reset; the head is only meaningful while level != 0.
    always_ff @(posedge clk) begin
        if (fifo.push && !fifo.flush) mem_q[wr_ptr_q] <= fifo.wdata;
    end

    assign fifo.rdata = mem_q[rd_ptr_q];
    assign fifo.level = level_q;

endmodule

// File: rtl/instr_issue.sv
// Host-to-pipeline instruction issuer: filters illegal opcodes, buffers legal ones, tracks the issue PC.
module instr_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [7:0]             host_op,
    input  logic [23:0]            host_imm,
    input  logic                   flush,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [31:0]            issue_instr,
    output logic [31:0]            issue_pc,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             illegal_cnt
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    instr_issue_if #(.DEPTH(DEPTH)) fifo_if ();

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (fifo_if.slave)
    );

    logic        host_accept;
    logic        op_legal;
    logic        do_pop;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  illegal_cnt_q, illegal_cnt_d;

    // host_ready depends only on the registered level, never on issue_ready.
    assign level       = fifo_if.level;
    assign host_ready  = (fifo_if.level != LW'(DEPTH));
    assign issue_valid = (fifo_if.level != '0);
    assign issue_instr = fifo_if.rdata;
    assign issue_pc    = pc_q;
    assign illegal_cnt = illegal_cnt_q;

    assign op_legal    = is_legal_op(host_op);
    assign host_accept = host_valid && host_ready && !flush;
    assign do_pop      = issue_valid && issue_ready && !flush;

    assign fifo_if.push  = host_accept && op_legal;
    assign fifo_if.pop   = do_pop;
    assign fifo_if.flush = flush;
    assign fifo_if.wdata = {host_imm, host_op};

    always_comb begin
        pc_d          = pc_q;
        illegal_cnt_d = illegal_cnt_q;
        if (do_pop) pc_d = pc_q + 32'd1;
        if (host_accept && !op_legal && (illegal_cnt_q != 8'hFF))
            illegal_cnt_d = illegal_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= '0;
            illegal_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios plus a randomized run against a queue model.
module tb_instr_issue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_valid;
    logic          host_ready;
    logic [7:0]    host_op;
    logic [23:0]   host_imm;
    logic          flush;
    logic          issue_valid;
    logic          issue_ready;
    logic [31:0]   issue_instr;
    logic [31:0]   issue_pc;
    logic [LW-1:0] level;
    logic [7:0]    illegal_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0]  m_q[$];
    logic [31:0]  m_pc;
    int unsigned  m_ill;

    instr_issue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_op     (host_op),
        .host_imm    (host_imm),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .level       (level),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: an instruction queue updated from the inputs seen at each rising edge.
    task automatic model_edge();
        int  lvl;
        bit  pop, push;
        lvl = m_q.size();
        if (!rst_n) begin
            m_q.delete();
            m_pc  = 32'd0;
            m_ill = 0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            pop  = (lvl != 0) && issue_ready;
            push = host_valid && (lvl != DEPTH);
            if (pop) begin
                void'(m_q.pop_front());
                m_pc = m_pc + 32'd1;
            end
            if (push) begin
                if (host_op inside {8'h01, 8'h02, 8'h03}) m_q.push_back({host_imm, host_op});
                else if (m_ill < 255) m_ill++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic hv, input logic [7:0] op, input logic [23:0] imm,
                         input logic fl, input logic ir);
        host_valid  = hv;
        host_op     = op;
        host_imm    = imm;
        flush       = fl;
        issue_ready = ir;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 8'h01, 24'h1, 1'b0, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
        #1;
        checks++; if (level !== 3'd0)       begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (host_ready !== 1'b1)  begin errors++; $display("FAIL reset_host_ready: got %b expected 1", host_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid); end
        checks++; if (issue_pc !== 32'd0)   begin errors++; $display("FAIL reset_pc: got %h expected 0", issue_pc); end
        checks++; if (illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_illegal: got %0d expected 0", illegal_cnt); end
    endtask

    task automatic test_basic_order();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h00000501;
        exp_i[1] = 32'h00000302;
        exp_i[2] = 32'h00000003;
        drive(1'b1, 8'h01, 24'd5, 1'b0, 1'b0);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b expected 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || level !== 3'd1) begin
            errors++; $display("FAIL first_latency: got valid=%b level=%0d expected valid=1 level=1", issue_valid, level);
        end
        drive(1'b1, 8'h02, 24'd3, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h03, 24'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (issue_valid !== 1'b1 || issue_instr !== exp_i[i] || issue_pc !== 32'(i)) begin
                errors++; $display("FAIL basic_issue[%0d]: got instr=%h pc=%0d expected instr=%h pc=%0d",
                                   i, issue_instr, issue_pc, exp_i[i], i);
            end
            tick();
        end
        checks++; if (level !== 3'd0 || issue_pc !== 32'd3) begin
            errors++; $display("FAIL basic_drained: got level=%0d pc=%0d expected level=0 pc=3", level, issue_pc);
        end
    endtask

    task automatic test_mul_stall();
        drive(1'b1, 8'h02, 24'd8, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h01, 24'd1, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (issue_instr !== 32'h00000802 || issue_pc !== 32'd3 || level !== 3'd2) begin
                errors++; $display("FAIL stall_hold[%0d]: got instr=%h pc=%0d level=%0d expected instr=00000802 pc=3 level=2",
                                   i, issue_instr, issue_pc, level);
            end
            tick();
        end
        issue_ready = 1'b1;
        tick();
        checks++; if (issue_instr !== 32'h00000101 || issue_pc !== 32'd4) begin
            errors++; $display("FAIL stall_release: got instr=%h pc=%0d expected instr=00000101 pc=4", issue_instr, issue_pc);
        end
        tick();
        checks++; if (level !== 3'd0 || issue_pc !== 32'd5) begin
            errors++; $display("FAIL stall_drained: got level=%0d pc=%0d expected level=0 pc=5", level, issue_pc);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h01, 24'(16 + i), 1'b0, 1'b0);
            tick();
        end
        checks++; if (level !== 3'd4 || host_ready !== 1'b0) begin
            errors++; $display("FAIL full_state: got level=%0d host_ready=%b expected level=4 host_ready=0", level, host_ready);
        end
        drive(1'b1, 8'h01, 24'hABC, 1'b0, 1'b1);
        tick();
        checks++; if (level !== 3'd3 || issue_pc !== 32'd6) begin
            errors++; $display("FAIL full_pop_no_push: got level=%0d pc=%0d expected level=3 pc=6", level, issue_pc);
        end
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            checks++; if (issue_instr !== {24'(16 + i), 8'h01}) begin
                errors++; $display("FAIL full_drain[%0d]: got %h expected %h", i, issue_instr, {24'(16 + i), 8'h01});
            end
            tick();
        end
        checks++; if (level !== 3'd0 || issue_pc !== 32'd9) begin
            errors++; $display("FAIL full_drained: got level=%0d pc=%0d expected level=0 pc=9", level, issue_pc);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1'b1, 8'h07, 24'h5, 1'b0, 1'b0); tick();
        checks++; if (illegal_cnt !== 8'd1 || level !== 3'd0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_7: got cnt=%0d level=%0d valid=%b expected 1 0 0", illegal_cnt, level, issue_valid);
        end
        drive(1'b1, 8'h00, 24'h5, 1'b0, 1'b0); tick();
        checks++; if (illegal_cnt !== 8'd2 || level !== 3'd0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_0: got cnt=%0d level=%0d valid=%b expected 2 0 0", illegal_cnt, level, issue_valid);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'hF0, 24'(i), 1'b0, 1'b0);
            tick();
            if (i == 251) begin
                checks++; if (illegal_cnt !== 8'd254) begin
                    errors++; $display("FAIL illegal_254: got %0d expected 254", illegal_cnt);
                end
            end
        end
        checks++; if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL illegal_sat: got %0d expected 255", illegal_cnt); end
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h01, 24'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h02, 24'h42, 1'b1, 1'b1);
        tick();
        checks++; if (level !== 3'd0 || issue_valid !== 1'b0 || issue_pc !== 32'd9 || illegal_cnt !== 8'd255) begin
            errors++; $display("FAIL flush: got level=%0d valid=%b pc=%0d ill=%0d expected 0 0 9 255",
                               level, issue_valid, issue_pc, illegal_cnt);
        end
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b1);
        tick();
        checks++; if (level !== 3'd0 || issue_pc !== 32'd9) begin
            errors++; $display("FAIL flush_after: got level=%0d pc=%0d expected 0 9", level, issue_pc);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_pc_wrap();
        drive(1'b1, 8'h01, 24'h77, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b0);
        force dut.pc_q = 32'hFFFF_FFFF;
        #1;
        release dut.pc_q;
        #1;
        checks++; if (issue_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pc_preload: got %h expected ffffffff", issue_pc); end
        issue_ready = 1'b1;
        tick();
        checks++; if (issue_pc !== 32'd0 || level !== 3'd0) begin
            errors++; $display("FAIL pc_wrap: got pc=%h level=%0d expected 0 0", issue_pc, level);
        end
        issue_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 8'h02, 24'd9, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h01, 24'd4, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b0); tick(); tick();
        rst_n = 1'b0;
        drive(1'b1, 8'h09, 24'd1, 1'b0, 1'b1);
        tick();
        checks++; if (level !== 3'd0 || issue_valid !== 1'b0 || host_ready !== 1'b1 ||
                      issue_pc !== 32'd0 || illegal_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_mid_stall: got level=%0d valid=%b ready=%b pc=%0d ill=%0d expected 0 0 1 0 0",
                               level, issue_valid, host_ready, issue_pc, illegal_cnt);
        end
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int i = 0; i < 600; i++) begin
            checks++; if (level !== LW'(m_q.size()) || host_ready !== (m_q.size() != DEPTH) ||
                          issue_valid !== (m_q.size() != 0) || issue_pc !== m_pc || illegal_cnt !== 8'(m_ill)) begin
                errors++; $display("FAIL random_state[%0d]: got level=%0d ready=%b valid=%b pc=%0d ill=%0d expected level=%0d pc=%0d ill=%0d",
                                   i, level, host_ready, issue_valid, issue_pc, illegal_cnt, m_q.size(), m_pc, m_ill);
            end
            if (m_q.size() != 0) begin
                checks++; if (issue_instr !== m_q[0]) begin
                    errors++; $display("FAIL random_instr[%0d]: got %h expected %h", i, issue_instr, m_q[0]);
                end
            end
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(1, 3));
            drive(($urandom_range(0, 3) != 0), op, 24'($urandom), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 2) != 0));
            tick();
        end
        drive(1'b0, 8'h00, 24'd0, 1'b0, 1'b0);
    endtask

    initial begin
        m_pc  = 32'd0;
        m_ill = 0;
        test_reset();
        test_basic_order();
        test_mul_stall();
        test_full();
        test_illegal();
        test_saturate();
        test_flush();
        test_pc_wrap();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instructions; a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 host_valid  input  1  host presents an instruction this cycle.
REQ-005 host_ready  output  1  block accepts a host instruction this cycle.
REQ-006 host_op  input  8  ALU command: 8'h1 ADD, 8'h2 MUL, 8'h3 CLR.
REQ-007 host_imm  input  24  immediate operand.
REQ-008 flush  input  1  discard all buffered instructions.
REQ-009 issue_valid  output  1  an instruction is offered to the pipeline fetch stage.
REQ-010 issue_ready  input  1  pipeline fetch accepts this cycle; low while a multiply is in progress.
REQ-011 issue_instr  output  32  offered instruction, {imm[23:0], op[7:0]}.
REQ-012 issue_pc  output  32  program counter of the offered instruction.
REQ-013 level  output  $clog2(DEPTH)+1  number of buffered instructions.
REQ-014 illegal_cnt  output  8  count of dropped illegal host instructions.

Function
REQ-015 host_ready SHALL equal (level != DEPTH), with no combinational path from issue_ready.
REQ-016 A push occurs when host_valid && host_ready && !flush.
REQ-017 A push with host_op in {1,2,3} SHALL store {host_imm, host_op} at the FIFO tail.
REQ-018 A push with any other host_op SHALL be consumed without storing and SHALL increment illegal_cnt, saturating at 255.
REQ-019 issue_valid SHALL equal (level != 0); issue_instr SHALL be the FIFO head, driven from storage.
REQ-020 A pop occurs when issue_valid && issue_ready && !flush; it advances the head and increments issue_pc by 1, wrapping from 2^32-1 to 0.
REQ-021 While issue_valid && !issue_ready, issue_instr and issue_pc SHALL hold stable; a multi-cycle MUL stall SHALL lose or duplicate nothing.
REQ-022 Latency: an instruction pushed into an empty FIFO at edge N SHALL appear on issue_valid/issue_instr after edge N; there is no same-cycle bypass.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH: level SHALL be unchanged and both SHALL take effect.
REQ-024 When full, a push is refused by host_ready=0 even if a pop occurs in the same cycle.
REQ-025 An illegal push together with a pop SHALL decrement level by 1.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; level disambiguates full from empty.
REQ-027 flush SHALL set level to 0 and empty the FIFO at the next edge, overriding any push or pop in that cycle.
REQ-028 flush SHALL leave issue_pc and illegal_cnt unchanged.
REQ-029 Flush-cycle handshakes: host_ready may be high but nothing is stored; an issue_ready handshake during flush does not advance issue_pc.

Reset
REQ-030 When rst_n=0 at an edge, the following SHALL take these values, regardless of other inputs and of any in-progress handshake:
- level=0, pointers=0, issue_pc=0, illegal_cnt=0
- issue_valid=0; host_ready=1 from the first cycle after reset
REQ-031 FIFO storage contents SHALL not be reset; issue_instr is don't-care while issue_valid=0.

Structure
REQ-032 The ALU command constants ALU_ADD=8'h1, ALU_MUL=8'h2 and ALU_CLR=8'h3, plus a legal-opcode check function, SHALL live in a shared package, alu_pkg, used by both pipeline and issuer.
REQ-033 Storage and pointer logic SHALL be one sub-module, issue_fifo (parameter DEPTH, width 32).
REQ-034 The opcode filter, pc and illegal counters SHALL be in instr_issue.

Verification
REQ-035 Reset, then push ADD imm=5, MUL imm=3, CLR -> issue_instr 32'h00000501, 32'h00000302, 32'h00000003 with issue_pc 0, 1, 2.
REQ-036 Push MUL imm=8 and ADD imm=1, then hold issue_ready=0 for 4 cycles -> MUL held stable with issue_pc constant; after release, ADD follows with issue_pc+1.
REQ-037 Push 4 legal instructions with issue_ready=0 -> level=4, host_ready=0; assert host_valid and issue_ready together -> one pop, no push, level=3.
REQ-038 Push op 8'h7 then op 8'h0 -> illegal_cnt=2, level=0, issue_valid stays 0.
REQ-039 Push 300 illegal ops -> illegal_cnt=255.
REQ-040 Fill to 3, then assert flush with host_valid and issue_ready both high -> level=0 and issue_pc unchanged next cycle.
REQ-041 Preload issue_pc to 32'hFFFFFFFF by forcing the register, then pop once -> issue_pc=0.
REQ-042 Assert rst_n=0 mid-stall -> all reset values after one edge.
